// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: CSR opcodes, CSR addresses, mstatus layout.
// Used by the machine-mode CSR file and its counter sub-module.
package riscv_pkg;

    typedef enum logic [1:0] {
        CSR_RW = 2'b01,
        CSR_RS = 2'b10,
        CSR_RC = 2'b11
    } csr_op_e;

    typedef enum logic [3:0] {
        EXC_INSTR_MISALIGN = 4'd0,
        EXC_ILLEGAL_INSTR  = 4'd2,
        EXC_BREAKPOINT     = 4'd3,
        EXC_ECALL_M        = 4'd11
    } exc_t;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;

    // New CSR value from the old one and the operand
    function automatic logic [31:0] csrApply(
        input csr_op_e     op,
        input logic [31:0] oldVal,
        input logic [31:0] wdata
    );
        logic [31:0] res;
        res = oldVal;
        case (op)
            CSR_RW:  res = wdata;
            CSR_RS:  res = oldVal | wdata;
            CSR_RC:  res = oldVal & ~wdata;
            default: res = oldVal;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit performance counter with independent 32-bit half writes.
// A half write in a cycle replaces that cycle's increment.
module csr_counter64
    import riscv_pkg::*;
(
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        inc_en,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    output logic [63:0] count
);

    // Half write wins over increment; wraps silently at 2^64
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            count <= '0;
        end else if (wr_lo) begin
            count[31:0] <= wdata;
        end else if (wr_hi) begin
            count[63:32] <= wdata;
        end else if (inc_en) begin
            count <= count + 64'd1;
        end
    end

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file: combinational read, clocked write/trap/mret.
// Define YARC_COUNTERS_EN to build the mcycle/minstret counter flops.
module csr_file
    import riscv_pkg::*;
#(
    parameter logic [31:0] HART_ID     = 32'd0,
    parameter logic [31:0] MISA_VALUE  = 32'h4000_0100,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        stall_i,
    input  logic        csr_read_i,
    input  logic        csr_write_i,
    input  csr_op_e     csr_op_i,
    input  logic [11:0] csr_addr_i,
    input  logic [31:0] csr_wdata_i,
    output logic [31:0] csr_rdata_o,
    output logic        illegal_o,
    input  logic        retire_i,
    input  logic        trap_i,
    input  logic [31:0] trap_cause_i,
    input  logic [31:0] trap_pc_i,
    input  logic        mret_i,
    output logic [31:0] mtvec_o,
    output logic [31:0] mepc_o,
    output logic        mie_o
);

    logic        mie;
    logic        mpie;
    logic [29:0] mtvecQ;
    logic [31:0] mscratch;
    logic [29:0] mepcQ;
    logic        mcauseIrq;
    logic [4:0]  mcauseCode;
    logic [63:0] mcycle;
    logic [63:0] minstret;

    logic [31:0] rdata;
    logic        known;
    logic        readOnly;
    logic [31:0] writeVal;
    logic        writeEn;
    logic        takeTrap;
    logic        takeMret;
    logic        unusedBits;

    // Address decode and read mux; unknown addresses read 0
    always_comb begin
        rdata    = '0;
        known    = 1'b1;
        readOnly = 1'b0;
        unique case (csr_addr_i)
            CSR_MSTATUS: begin
                rdata[MSTATUS_MIE_BIT]  = mie;
                rdata[MSTATUS_MPIE_BIT] = mpie;
            end
            CSR_MISA: begin
                rdata    = MISA_VALUE;
                readOnly = 1'b1;
            end
            CSR_MTVEC:     rdata = {mtvecQ, 2'b00};
            CSR_MSCRATCH:  rdata = mscratch;
            CSR_MEPC:      rdata = {mepcQ, 2'b00};
            CSR_MCAUSE:    rdata = {mcauseIrq, 26'd0, mcauseCode};
            CSR_MCYCLE:    rdata = mcycle[31:0];
            CSR_MCYCLEH:   rdata = mcycle[63:32];
            CSR_MINSTRET:  rdata = minstret[31:0];
            CSR_MINSTRETH: rdata = minstret[63:32];
            CSR_CYCLE: begin
                rdata    = mcycle[31:0];
                readOnly = 1'b1;
            end
            CSR_CYCLEH: begin
                rdata    = mcycle[63:32];
                readOnly = 1'b1;
            end
            CSR_INSTRET: begin
                rdata    = minstret[31:0];
                readOnly = 1'b1;
            end
            CSR_INSTRETH: begin
                rdata    = minstret[63:32];
                readOnly = 1'b1;
            end
            CSR_MHARTID: begin
                rdata    = HART_ID;
                readOnly = 1'b1;
            end
            default: known = 1'b0;
        endcase
    end

    assign csr_rdata_o = rdata;
    assign illegal_o   = ((csr_read_i | csr_write_i) & ~known)
                       | (csr_write_i & readOnly);

    assign writeVal = csrApply(csr_op_i, rdata, csr_wdata_i);
    assign writeEn  = csr_write_i & ~illegal_o & ~stall_i & ~trap_i;
    assign takeTrap = trap_i & ~stall_i;
    assign takeMret = mret_i & ~stall_i & ~trap_i;

    assign mtvec_o = {mtvecQ, 2'b00};
    assign mepc_o  = {mepcQ, 2'b00};
    assign mie_o   = mie;

    assign unusedBits = ^{trap_pc_i[1:0], trap_cause_i[30:5]};

    // mstatus: trap beats mret beats a software write
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            mie  <= 1'b0;
            mpie <= 1'b0;
        end else if (takeTrap) begin
            mpie <= mie;
            mie  <= 1'b0;
        end else if (takeMret) begin
            mie  <= mpie;
            mpie <= 1'b1;
        end else if (writeEn && csr_addr_i == CSR_MSTATUS) begin
            mie  <= writeVal[MSTATUS_MIE_BIT];
            mpie <= writeVal[MSTATUS_MPIE_BIT];
        end
    end

    // mtvec: word aligned, software write only
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            mtvecQ <= MTVEC_RESET[31:2];
        end else if (writeEn && csr_addr_i == CSR_MTVEC) begin
            mtvecQ <= writeVal[31:2];
        end
    end

    // mscratch: plain 32-bit scratch register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            mscratch <= '0;
        end else if (writeEn && csr_addr_i == CSR_MSCRATCH) begin
            mscratch <= writeVal;
        end
    end

    // mepc: captures the trapping PC, else software write
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            mepcQ <= '0;
        end else if (takeTrap) begin
            mepcQ <= trap_pc_i[31:2];
        end else if (writeEn && csr_addr_i == CSR_MEPC) begin
            mepcQ <= writeVal[31:2];
        end
    end

    // mcause: keeps interrupt flag and 5-bit code only
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            mcauseIrq  <= 1'b0;
            mcauseCode <= '0;
        end else if (takeTrap) begin
            mcauseIrq  <= trap_cause_i[31];
            mcauseCode <= trap_cause_i[4:0];
        end else if (writeEn && csr_addr_i == CSR_MCAUSE) begin
            mcauseIrq  <= writeVal[31];
            mcauseCode <= writeVal[4:0];
        end
    end

`ifdef YARC_COUNTERS_EN
    logic cycWrLo;
    logic cycWrHi;
    logic insWrLo;
    logic insWrHi;
    logic insInc;

    assign cycWrLo = writeEn & (csr_addr_i == CSR_MCYCLE);
    assign cycWrHi = writeEn & (csr_addr_i == CSR_MCYCLEH);
    assign insWrLo = writeEn & (csr_addr_i == CSR_MINSTRET);
    assign insWrHi = writeEn & (csr_addr_i == CSR_MINSTRETH);
    assign insInc  = retire_i & ~stall_i;

    csr_counter64 uCycle (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .inc_en (1'b1),
        .wr_lo  (cycWrLo),
        .wr_hi  (cycWrHi),
        .wdata  (writeVal),
        .count  (mcycle)
    );

    csr_counter64 uInstret (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .inc_en (insInc),
        .wr_lo  (insWrLo),
        .wr_hi  (insWrHi),
        .wdata  (writeVal),
        .count  (minstret)
    );
`else
    logic unusedRetire;

    assign mcycle       = '0;
    assign minstret     = '0;
    assign unusedRetire = retire_i;
`endif

endmodule
